jtframe_prog_packer: RTL

//  Sits directly downstream of the MiSTer download unit. Consumes the ioctl byte stream and packs

---
 rtl/jtframe_prog_packer_if.sv | 13 +
 rtl/jtframe_prog_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_prog_packer_if.sv
// SDRAM programming port bundle between the byte packer (master) and the SDRAM controller (slave).
interface jtframe_prog_packer_if #(
    parameter int PROG_AW = 22
);
    logic [PROG_AW-1:0] prog_addr;
    logic [15:0]        prog_data;
    logic [1:0]         prog_mask;
    logic               prog_we;
    logic               prog_rdy;

    modport master (output prog_addr, prog_data, prog_mask, prog_we, input prog_rdy);
    modport slave  (input prog_addr, prog_data, prog_mask, prog_we, output prog_rdy);
endinterface

// File: rtl/jtframe_prog_packer.sv
// Packs the ioctl byte stream into 16-bit SDRAM words through a small FIFO and drives the prog port.
// Optional JTFRAME_PROG_CHKSUM_EN adds a running sum of every accepted word on the chksum port.
module jtframe_prog_packer #(
    parameter int FIFO_AW = 3,
    parameter int PROG_AW = 22
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         downloading,
    input  logic                         ioctl_rom_wr,
    input  logic [26:0]                  ioctl_addr,
    input  logic [7:0]                   ioctl_dout,
    output logic                         dwnld_busy,
    jtframe_prog_packer_if.master        prog,
    output logic                         prog_done,
    output logic                         ovf
`ifdef JTFRAME_PROG_CHKSUM_EN
    ,
    output logic [15:0]                  chksum
`endif
);
    localparam int EW = PROG_AW + 18;
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [FIFO_AW:0] BUSY_LVL = DEPTH_C - (FIFO_AW+1)'(2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic                 pend_valid_q, pend_valid_d;
    logic [PROG_AW-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [EW-1:0]        skid_q, skid_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     fill_q, fill_d;
    logic [1:0]           state_q, state_d;
    logic [PROG_AW-1:0]   prog_addr_q, prog_addr_d;
    logic [15:0]          prog_data_q, prog_data_d;
    logic [1:0]           prog_mask_q, prog_mask_d;
    logic                 prog_we_q, prog_we_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic                 dl_q;
    logic                 done_arm_q, done_arm_d;
    logic                 prog_done_q, prog_done_d;
    logic [15:0]          chksum_q, chksum_d;

    logic [EW-1:0]        fifo_mem [1 << FIFO_AW];
    logic [EW-1:0]        head, new0, new1, flush_entry, push_entry;
    logic [1:0]           n_new;
    logic [PROG_AW-1:0]   byte_addr;
    logic                 push_req, push_ok, pop, fifo_full, fifo_empty, dl_rise, dl_fall;
    logic                 unused_addr;

    assign byte_addr   = ioctl_addr[PROG_AW:1];
    assign unused_addr = ^ioctl_addr[26:PROG_AW+1];
    assign flush_entry = {pend_addr_q, 8'h00, pend_data_q, 2'b10};
    assign fifo_full   = fill_q == DEPTH_C;
    assign fifo_empty  = fill_q == '0;
    assign head        = fifo_mem[rd_ptr_q];
    assign dl_rise     = downloading & ~dl_q;
    assign dl_fall     = ~downloading & dl_q;

    // Byte pairing: up to two words can come out of one strobe; the second waits in the skid entry.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        n_new        = 2'd0;
        new0         = '0;
        new1         = '0;
        if (ioctl_rom_wr) begin
            if (!ioctl_addr[0]) begin
                if (pend_valid_q) begin
                    new0  = flush_entry;
                    n_new = 2'd1;
                end
                pend_valid_d = 1'b1;
                pend_addr_d  = byte_addr;
                pend_data_d  = ioctl_dout;
            end else begin
                pend_valid_d = 1'b0;
                if (pend_valid_q && pend_addr_q == byte_addr) begin
                    new0  = {byte_addr, ioctl_dout, pend_data_q, 2'b00};
                    n_new = 2'd1;
                end else if (pend_valid_q) begin
                    new0  = flush_entry;
                    new1  = {byte_addr, ioctl_dout, 8'h00, 2'b01};
                    n_new = 2'd2;
                end else begin
                    new0  = {byte_addr, ioctl_dout, 8'h00, 2'b01};
                    n_new = 2'd1;
                end
            end
        end else if (pend_valid_q && !downloading) begin
            new0         = flush_entry;
            n_new        = 2'd1;
            pend_valid_d = 1'b0;
        end

        // A full skid implies no pending byte, so at most one new word can arrive alongside it.
        if (skid_valid_q) begin
            push_req     = 1'b1;
            push_entry   = skid_q;
            skid_valid_d = n_new != 2'd0;
            skid_d       = new0;
        end else begin
            push_req     = n_new != 2'd0;
            push_entry   = new0;
            skid_valid_d = n_new == 2'd2;
            skid_d       = new1;
        end
    end

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prog_we_d   = prog_we_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                {prog_addr_d, prog_data_d, prog_mask_d} = head;
                prog_we_d = 1'b1;
                state_d   = ST_WRITE;
            end
            ST_WRITE: if (prog.prog_rdy) begin
                prog_we_d = 1'b0;
                pop       = 1'b1;
                state_d   = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A push against a full FIFO is dropped even when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok  = push_req & ~fifo_full;
        wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok && !pop)
            fill_d = fill_q + (FIFO_AW+1)'(1);
        else if (pop && !push_ok)
            fill_d = fill_q - (FIFO_AW+1)'(1);
        busy_d = fill_d >= BUSY_LVL;
        ovf_d  = dl_rise ? 1'b0 : ovf_q;
        if (push_req && fifo_full)
            ovf_d = 1'b1;
        prog_done_d = done_arm_q && !downloading && !ioctl_rom_wr && !pend_valid_q
                      && !skid_valid_q && fifo_empty && state_q == ST_IDLE;
        done_arm_d  = done_arm_q;
        if (dl_fall)
            done_arm_d = 1'b1;
        else if (dl_rise || prog_done_d)
            done_arm_d = 1'b0;
        chksum_d = chksum_q;
        if (dl_rise)
            chksum_d = '0;
        else if (pop)
            chksum_d = chksum_q + {prog_mask_q[1] ? 8'h00 : prog_data_q[15:8],
                                   prog_mask_q[0] ? 8'h00 : prog_data_q[7:0]};
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            state_q      <= ST_IDLE;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            prog_mask_q  <= '0;
            prog_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            dl_q         <= 1'b0;
            done_arm_q   <= 1'b0;
            prog_done_q  <= 1'b0;
            chksum_q     <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            state_q      <= state_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            prog_mask_q  <= prog_mask_d;
            prog_we_q    <= prog_we_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            dl_q         <= downloading;
            done_arm_q   <= done_arm_d;
            prog_done_q  <= prog_done_d;
            chksum_q     <= chksum_d;
        end
    end

    assign prog.prog_addr = prog_addr_q;
    assign prog.prog_data = prog_data_q;
    assign prog.prog_mask = prog_mask_q;
    assign prog.prog_we   = prog_we_q;
    assign dwnld_busy     = busy_q;
    assign ovf            = ovf_q;
    assign prog_done      = prog_done_q & ~downloading;
`ifdef JTFRAME_PROG_CHKSUM_EN
    assign chksum = chksum_q;
`else
    logic unused_chksum;
    assign unused_chksum = ^chksum_q;
`endif
endmodule
